// File: rtl/vend_ctrl_param_if.sv
// vend_ctrl_param_if: coin-acceptor / dispenser / hopper signal bundle for vend_ctrl_param
interface vend_ctrl_param_if #(parameter int CW = 4);
  logic coin_5;
  logic coin_10;
  logic coin_20;
  logic cancel;
  logic dispense;
  logic change_5;
  logic change_10;
  logic coin_reject;
  logic [CW-1:0] credit;
  logic busy;
  modport master (
    output coin_5, coin_10, coin_20, cancel,
    input  dispense, change_5, change_10, coin_reject, credit, busy
  );
  modport slave (
    input  coin_5, coin_10, coin_20, cancel,
    output dispense, change_5, change_10, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller, accumulates credit, dispenses, pays change largest coin first
module vend_ctrl_param #(
  parameter int PRICE = 3,
  parameter int CW = 4
) (
  input logic clk,
  input logic rst,
  vend_ctrl_param_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
  localparam logic [CW-1:0] PRICE_N = CW'(PRICE);
  state_t r_state;
  logic [CW-1:0] r_credit;
  logic r_dispense, r_change_5, r_change_10, r_coin_reject;
  logic w_any_coin, w_multi, w_over, w_two, w_reject;
  logic [CW:0] w_add, w_sum;
  logic [CW-1:0] w_rem, w_credit_dec;
  assign w_any_coin = bus.coin_5 | bus.coin_10 | bus.coin_20;
  assign w_multi = (bus.coin_5 & bus.coin_10) | (bus.coin_5 & bus.coin_20) | (bus.coin_10 & bus.coin_20);
  assign w_add = bus.coin_20 ? (CW+1)'(4) : bus.coin_10 ? (CW+1)'(2) : (CW+1)'(1);
  assign w_sum = {1'b0, r_credit} + w_add;
  // the sum only overflows the credit register when its extra top bit is set
  assign w_over = w_sum[CW];
  assign w_rem = w_sum[CW-1:0] - PRICE_N;
  assign w_two = r_credit[CW-1:1] != '0;
  assign w_credit_dec = r_credit - (w_two ? CW'(2) : CW'(1));
  assign w_reject = (r_state != IDLE || bus.cancel) ? w_any_coin : (w_multi | (w_any_coin & w_over));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_credit <= '0;
      r_dispense <= 1'b0;
      r_change_5 <= 1'b0;
      r_change_10 <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_dispense <= 1'b0;
      r_change_5 <= 1'b0;
      r_change_10 <= 1'b0;
      r_coin_reject <= w_reject;
      case (r_state)
        IDLE: begin
          if (bus.cancel) begin
            if (r_credit != '0) r_state <= CHANGE;
          end else if (w_any_coin && !w_multi && !w_over) begin
            if (w_sum >= PRICE_W) begin
              r_credit <= w_rem;
              r_dispense <= 1'b1;
              r_state <= DISPENSE;
            end else begin
              r_credit <= w_sum[CW-1:0];
            end
          end
        end
        DISPENSE: r_state <= (r_credit != '0) ? CHANGE : IDLE;
        CHANGE: begin
          r_change_10 <= w_two;
          r_change_5 <= ~w_two;
          r_credit <= w_credit_dec;
          if (w_credit_dec == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.dispense = r_dispense;
  assign bus.change_5 = r_change_5;
  assign bus.change_10 = r_change_10;
  assign bus.coin_reject = r_coin_reject;
  assign bus.credit = r_credit;
  assign bus.busy = r_state != IDLE;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: three price configurations driven in parallel, checked against a change-schedule model
module tb_vend_ctrl_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c5 = 1'b0, c10 = 1'b0, c20 = 1'b0, cn = 1'b0;
  always #5 clk = ~clk;
  vend_ctrl_param_if #(.CW(4)) b3 ();
  vend_ctrl_param_if #(.CW(4)) b1 ();
  vend_ctrl_param_if #(.CW(4)) b15 ();
  assign {b3.coin_5, b3.coin_10, b3.coin_20, b3.cancel} = {c5, c10, c20, cn};
  assign {b1.coin_5, b1.coin_10, b1.coin_20, b1.cancel} = {c5, c10, c20, cn};
  assign {b15.coin_5, b15.coin_10, b15.coin_20, b15.cancel} = {c5, c10, c20, cn};
  vend_ctrl_param #(.PRICE(3), .CW(4)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  vend_ctrl_param #(.PRICE(1), .CW(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  vend_ctrl_param #(.PRICE(15), .CW(4)) u15 (.clk(clk), .rst(rst), .bus(b15.slave));
  logic [8:0] ob [3];
  assign ob[0] = {b3.dispense, b3.change_5, b3.change_10, b3.coin_reject, b3.busy, b3.credit};
  assign ob[1] = {b1.dispense, b1.change_5, b1.change_10, b1.coin_reject, b1.busy, b1.credit};
  assign ob[2] = {b15.dispense, b15.change_5, b15.change_10, b15.coin_reject, b15.busy, b15.credit};
  typedef struct {
    logic disp;
    logic c5;
    logic c10;
    logic rej;
    logic busy;
    int cr;
  } exp_t;
  exp_t mq [3][$];
  int m_cr [3];
  int price [3] = '{3, 1, 15};
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // change is paid as many 10-coins as fit, then at most one 5-coin
  task automatic push_change(input int i, input int amount);
    exp_t e;
    int r = amount;
    for (int k = 0; k < amount / 2 + amount % 2; k++) begin
      e = '{default: 0};
      e.c10 = (k < amount / 2);
      e.c5 = !e.c10;
      r -= e.c10 ? 2 : 1;
      e.cr = r;
      e.busy = (r != 0);
      mq[i].push_back(e);
    end
  endtask
  task automatic model(input int i, output exp_t e);
    exp_t d;
    int n = int'(c5) + int'(c10) + int'(c20);
    int add = c20 ? 4 : c10 ? 2 : 1;
    e = '{default: 0};
    if (rst) begin
      mq[i].delete();
    end else if (mq[i].size() > 0) begin
      e = mq[i].pop_front();
      e.rej = (n > 0);
    end else begin
      e.cr = m_cr[i];
      if (cn) begin
        e.rej = (n > 0);
        if (m_cr[i] > 0) begin
          e.busy = 1'b1;
          push_change(i, m_cr[i]);
        end
      end else if (n > 1) begin
        e.rej = 1'b1;
      end else if (n == 1) begin
        if (m_cr[i] + add > 15) e.rej = 1'b1;
        else if (m_cr[i] + add >= price[i]) begin
          e.cr = m_cr[i] + add - price[i];
          e.disp = 1'b1;
          e.busy = 1'b1;
          d = '{default: 0};
          d.cr = e.cr;
          d.busy = (e.cr > 0);
          mq[i].push_back(d);
          push_change(i, e.cr);
        end else e.cr = m_cr[i] + add;
      end
    end
    m_cr[i] = e.cr;
  endtask
  task automatic cyc(input logic a5, input logic a10, input logic a20, input logic ac, input logic ar);
    exp_t e;
    {c5, c10, c20, cn, rst} = {a5, a10, a20, ac, ar};
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model(i, e);
      chk($sformatf("p%0d dispense", price[i]), 32'(ob[i][8]), 32'(e.disp));
      chk($sformatf("p%0d change_5", price[i]), 32'(ob[i][7]), 32'(e.c5));
      chk($sformatf("p%0d change_10", price[i]), 32'(ob[i][6]), 32'(e.c10));
      chk($sformatf("p%0d coin_reject", price[i]), 32'(ob[i][5]), 32'(e.rej));
      chk($sformatf("p%0d busy", price[i]), 32'(ob[i][4]), 32'(e.busy));
      chk($sformatf("p%0d credit", price[i]), 32'(ob[i][3:0]), 32'(e.cr));
    end
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask
  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset outputs p3", 32'(ob[0]), 32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("p3 first 5 credit", 32'(ob[0][3:0]), 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("p3 second 5 credit", 32'(ob[0][3:0]), 32'd2);
    cyc(1, 0, 0, 0, 0);
    chk("p3 third 5 dispense", 32'(ob[0][8]), 32'd1);
    idle(1);
    chk("p3 busy one cycle", 32'(ob[0][4]), 32'd0);
    idle(8);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("p3 10+10 credit after dispense", 32'(ob[0][3:0]), 32'd1);
    idle(1);
    idle(1);
    chk("p3 change_5 after 10+10", 32'(ob[0][7]), 32'd1);
    idle(8);
    cyc(0, 0, 1, 0, 0);
    chk("p1 coin_20 credit", 32'(ob[1][3:0]), 32'd3);
    idle(2);
    chk("p1 change_10 first", 32'(ob[1][6]), 32'd1);
    idle(1);
    chk("p1 change_5 second", 32'(ob[1][7]), 32'd1);
    idle(8);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(1);
    chk("p15 refund change_10", 32'(ob[2][6]), 32'd1);
    idle(8);
    cyc(0, 0, 0, 1, 0);
    chk("cancel at zero credit", 32'(ob[2]), 32'd0);
    cyc(1, 1, 0, 0, 0);
    chk("double coin reject", 32'(ob[2][5]), 32'd1);
    idle(8);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 1, 0, 0);
      idle(8);
    end
    cyc(0, 1, 0, 0, 0);
    chk("p15 credit 14", 32'(ob[2][3:0]), 32'd14);
    idle(8);
    cyc(0, 1, 0, 0, 0);
    chk("p15 overflow reject", 32'(ob[2][5]), 32'd1);
    cyc(1, 0, 0, 0, 0);
    chk("p15 exact price dispense", 32'(ob[2][8]), 32'd1);
    idle(8);
    cyc(0, 0, 1, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0);
    chk("p1 coin during change rejected", 32'(ob[1][5]), 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("p1 reset mid change", 32'(ob[1]), 32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("p1 dispense after reset", 32'(ob[1][8]), 32'd1);
    idle(8);
    for (int k = 0; k < 4000; k++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending-machine controller, the next generation of the fixed 15-unit, two-coin seller FSM. It accumulates credit from three coin denominations into a counter, with price and credit width set by parameters. On reaching the price it dispenses and then pays out change serially, largest coin first. It also supports a cancel/refund request and rejects coins that cannot be accepted, and it sits between the coin-acceptor front end and the dispenser/hopper drivers.

## Interface
- PRICE, default 3: product price in units of 5 (3 = 15); legal range 1 .. 2^CW-1.
- CW, default 4: credit register width; MAX_CREDIT = 2^CW-1 units.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- coin_5  in  1  one 5-coin (1 unit) presented this cycle.
- coin_10  in  1  one 10-coin (2 units) presented this cycle.
- coin_20  in  1  one 20-coin (4 units) presented this cycle.
- cancel  in  1  refund request; acted on only in IDLE.
- dispense  out  1  registered one-cycle product release pulse.
- change_5  out  1  registered one-cycle pulse, pay out one 5-coin.
- change_10  out  1  registered one-cycle pulse, pay out one 10-coin.
- coin_reject  out  1  registered one-cycle pulse, the coin sampled last edge was returned.
- credit  out  CW  current credit register, in units.
- busy  out  1  high when state != IDLE.

## Operation
- States: IDLE, DISPENSE, CHANGE; 2-bit encoding.
- Coin value add = 1/2/4 for coin_5/coin_10/coin_20; exactly one coin high = valid coin.
- IDLE, at each edge, in priority order:
  - cancel=1 and credit>0: go to CHANGE (refund); any coin this cycle is rejected.
  - cancel=1 and credit=0: no action; any coin this cycle is rejected.
  - More than one coin high: all rejected, coin_reject=1, credit unchanged.
  - Valid coin with credit+add > MAX_CREDIT: rejected, credit unchanged. Compute the sum CW+1 bits wide.
  - Valid coin with credit+add >= PRICE: credit <= credit+add-PRICE, dispense<=1, go to DISPENSE.
  - Valid coin otherwise: credit <= credit+add, stay in IDLE.
- DISPENSE, one cycle: next state is CHANGE if credit>0, else IDLE.
- CHANGE, at each edge:
  - If credit>=2: change_10<=1 and credit -= 2; else change_5<=1 and credit -= 1.
  - When the new credit is 0, go to IDLE at the same edge.
- Any coin asserted outside IDLE is rejected (coin_reject=1); cancel outside IDLE is ignored.
- dispense, change_5, change_10 and coin_reject default to 0 on every edge not setting them. At most one of change_5/change_10 is high per cycle.

## Timing
- Reset, sampled at an edge: state=IDLE, credit=0, dispense=change_5=change_10=coin_reject=0, busy=0.
  - Reset mid-DISPENSE or mid-CHANGE aborts the operation; outstanding change is discarded.
- Coin sampled at edge E: credit, dispense and coin_reject are visible in the cycle after E.
- Purchase sequence:
  - Edge E: dispense high for cycle E..E+1; state is DISPENSE.
  - Edge E+1: enters CHANGE (credit>0) or IDLE.
  - First change pulse from edge E+2, one coin per cycle, no gaps.
  - busy falls at the edge emitting the last change pulse.
- Refund: cancel sampled at edge E enters CHANGE; first change pulse from edge E+1.
- Coins and cancel are sampled levels; upstream presents each coin for exactly one cycle.
- Maximum CHANGE length is ceil(MAX_CREDIT/2) cycles.

## Test plan
- PRICE=3: coin_5 on three separate cycles → credit 1, 2, then dispense=1 for one cycle, credit=0, no change pulses, busy high for 1 cycle.
- PRICE=3: coin_10, coin_10 → dispense at second coin with credit=1; one change_5 pulse 2 cycles after dispense; then IDLE.
- PRICE=1: coin_20 → dispense, credit=3; change_10 then change_5 on consecutive cycles; credit 1 then 0.
- PRICE=3: coin_10 then cancel → no dispense, one change_10 pulse the cycle after cancel. cancel with credit=0 → no outputs.
- Rejects:
  - coin_5 and coin_10 together → coin_reject=1, credit unchanged.
  - coin_5 during CHANGE → coin_reject=1.
  - PRICE=15, CW=4 with credit=14, coin_10 → rejected.
  - Same setup, coin_5 → dispense, credit=0.
- Reset during CHANGE after PRICE=1 coin_20 → all outputs 0, credit 0, IDLE next cycle; a subsequent coin_5 dispenses normally.
